// File: rtl/wb_write_arbiter.sv
// Write-back arbiter: merges ALU and load-unit results into a small in-order
// FIFO and retires one register-file write per cycle. It also reports whether
// a register still has a write that has not yet committed, so decode can stall.
module wb_write_arbiter #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 32,
  parameter int DEPTH     = 4
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_BITS-1:0]   alu_rd,
  input  logic [DATA_BITS-1:0]   alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [ADDR_BITS-1:0]   ld_rd,
  input  logic [DATA_BITS-1:0]   ld_data,
  output logic                   Write_enable,
  output logic [ADDR_BITS-1:0]   Write_reg,
  output logic [DATA_BITS-1:0]   Write_data,
  input  logic [ADDR_BITS-1:0]   chk_reg1,
  input  logic [ADDR_BITS-1:0]   chk_reg2,
  output logic                   chk_pend1,
  output logic                   chk_pend2,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]     DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]     CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0]     CNT_TWO  = CNT_W'(32'd2);
  localparam logic [PTR_W-1:0]     PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(32'd1);
  localparam logic [ADDR_BITS-1:0] REG_X0   = {ADDR_BITS{1'b0}};

  // Queue storage; entries outside the live window are never looked at,
  // so the array itself needs no reset.
  logic [ADDR_BITS-1:0] fifo_rd_r   [DEPTH];
  logic [DATA_BITS-1:0] fifo_data_r [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic                 we_r;
  logic [ADDR_BITS-1:0] wreg_r;
  logic [DATA_BITS-1:0] wdata_r;

  logic [CNT_W-1:0]     free_s;
  logic [CNT_W-1:0]     push_cnt_s;
  logic [CNT_W-1:0]     pop_cnt_s;
  logic [PTR_W-1:0]     ld_slot_s;
  logic                 alu_ready_s;
  logic                 ld_ready_s;
  logic                 alu_push_s;
  logic                 ld_push_s;
  logic                 pop_s;
  logic [DEPTH-1:0]     live_s;
  logic                 pend1_s;
  logic                 pend2_s;

  // Handshake and push decode; free space is judged on start-of-cycle
  // occupancy only, so a same-cycle pop never frees a slot early.
  always_comb begin
    free_s = DEPTH_C - count_r;
    if (rst) begin
      alu_ready_s = 1'b0;
      ld_ready_s  = 1'b0;
    end else begin
      alu_ready_s = (free_s >= CNT_ONE);
      if (alu_valid) begin
        ld_ready_s = (free_s >= CNT_TWO);
      end else begin
        ld_ready_s = (free_s >= CNT_ONE);
      end
    end
    // x0 results complete the handshake but never occupy a slot.
    alu_push_s = alu_valid & alu_ready_s & (alu_rd != REG_X0);
    ld_push_s  = ld_valid & ld_ready_s & (ld_rd != REG_X0);
    // The ALU entry is older, so the load lands one slot behind it.
    if (alu_push_s) begin
      ld_slot_s = wr_ptr_r + PTR_ONE;
    end else begin
      ld_slot_s = wr_ptr_r;
    end
    push_cnt_s = {{(CNT_W-1){1'b0}}, alu_push_s} + {{(CNT_W-1){1'b0}}, ld_push_s};
    pop_s      = (count_r != CNT_ZERO);
    pop_cnt_s  = {{(CNT_W-1){1'b0}}, pop_s};
  end

  // Store accepted results into their slots.
  always_ff @(posedge CLK) begin
    if (alu_push_s) begin
      fifo_rd_r[wr_ptr_r]   <= alu_rd;
      fifo_data_r[wr_ptr_r] <= alu_data;
    end
    if (ld_push_s) begin
      fifo_rd_r[ld_slot_s]   <= ld_rd;
      fifo_data_r[ld_slot_s] <= ld_data;
    end
  end

  // Pointers, occupancy and the registered register-file write port.
  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      we_r     <= 1'b0;
      wreg_r   <= REG_X0;
      wdata_r  <= {DATA_BITS{1'b0}};
    end else begin
      // DEPTH is a power of two, so pointer wrap is plain truncation.
      wr_ptr_r <= wr_ptr_r + push_cnt_s[PTR_W-1:0];
      rd_ptr_r <= rd_ptr_r + pop_cnt_s[PTR_W-1:0];
      count_r  <= count_r + push_cnt_s - pop_cnt_s;
      if (pop_s) begin
        we_r    <= 1'b1;
        wreg_r  <= fifo_rd_r[rd_ptr_r];
        wdata_r <= fifo_data_r[rd_ptr_r];
      end else begin
        we_r    <= 1'b0;
        wreg_r  <= wreg_r;
        wdata_r <= wdata_r;
      end
    end
  end

  // Mark which slots currently hold queued entries (distance from head < count).
  always_comb begin
    live_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      live_s[i] = ({1'b0, PTR_W'(i) - rd_ptr_r} < count_r);
    end
  end

  // Pending-write lookup over queued entries plus the write now on the port.
  always_comb begin
    pend1_s = 1'b0;
    pend2_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pend1_s = pend1_s | (live_s[i] & (fifo_rd_r[i] == chk_reg1));
      pend2_s = pend2_s | (live_s[i] & (fifo_rd_r[i] == chk_reg2));
    end
    pend1_s = pend1_s | (we_r & (wreg_r == chk_reg1));
    pend2_s = pend2_s | (we_r & (wreg_r == chk_reg2));
    // x0 is hard-wired, so it can never be pending.
    pend1_s = pend1_s & (chk_reg1 != REG_X0);
    pend2_s = pend2_s & (chk_reg2 != REG_X0);
  end

  assign alu_ready    = alu_ready_s;
  assign ld_ready     = ld_ready_s;
  assign Write_enable = we_r;
  assign Write_reg    = wreg_r;
  assign Write_data   = wdata_r;
  assign chk_pend1    = pend1_s;
  assign chk_pend2    = pend2_s;
  assign count        = count_r;

endmodule
